// File: rtl/fir_pkg.sv
// Shared types, default Q1.15 coefficients and sizing/rounding helpers for the
// time-multiplexed symmetric FIR.
package fir_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MAC   = 2'd1,
      S_ROUND = 2'd2,
      S_OUT   = 2'd3
   } fir_state_t;

   localparam int DEF_NU     = 6;
   localparam int DEF_COEF_W = 16;

   typedef logic signed [DEF_COEF_W-1:0] def_coef_t;

   // c0..c5 for the 11-tap default response; c5 is the centre tap
   localparam def_coef_t DEF_COEF [DEF_NU] = '{
      16'sd164, -16'sd983, 16'sd1311, -16'sd1966, 16'sd4915, 16'sd16384
   };

   function automatic int calc_nu(input int n_taps);
      return (n_taps + 1) / 2;
   endfunction

   function automatic int calc_acc_w(input int data_w, input int coef_w, input int n_taps);
      return data_w + coef_w + 1 + $clog2(calc_nu(n_taps));
   endfunction

   // Unique coefficients beyond the default table start at zero.
   function automatic def_coef_t def_coef(input int i);
      def_coef_t c;
      c = '0;
      for (int k = 0; k < DEF_NU; k++) begin
         if (k == i) c = DEF_COEF[k];
      end
      return c;
   endfunction

   // Round half up, arithmetic shift, then clamp to a signed out_w range.
   // The accumulator arrives sign-extended to 64 bits.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                    input int shift,
                                                    input int out_w);
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/fir_sym_tdm_if.sv
// Sample-in / sample-out valid-ready streams of fir_sym_tdm.
// master = source/sink side, slave = the filter.
interface fir_sym_tdm_if #(
   parameter int DATA_W = 16,
   parameter int OUT_W  = 16
);
   logic signed [DATA_W-1:0] in_data;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [OUT_W-1:0]  out_data;
   logic                     out_valid;
   logic                     out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/fir_preadd_mac.sv
// Symmetric pre-adder, signed multiplier and accumulator with clear and enable.
// The centre tap is passed through the pre-adder without doubling.
module fir_preadd_mac
   import fir_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int ACC_W  = 36
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     en,
   input  logic                     centre,
   input  logic signed [DATA_W-1:0] tap_a,
   input  logic signed [DATA_W-1:0] tap_b,
   input  logic signed [COEF_W-1:0] coef,
   output logic signed [ACC_W-1:0]  acc
);

   localparam int PRE_W  = DATA_W + 1;
   localparam int PROD_W = PRE_W + COEF_W;

   logic signed [PRE_W-1:0]  pre;
   logic signed [PROD_W-1:0] prod;

   always_comb begin
      pre = {tap_a[DATA_W-1], tap_a};
      if (!centre) pre = {tap_a[DATA_W-1], tap_a} + {tap_b[DATA_W-1], tap_b};
      prod = PROD_W'(pre) * PROD_W'(coef);
   end

   always_ff @(posedge clk) begin
      if (rst || clr) acc <= '0;
      else if (en)    acc <= acc + ACC_W'(prod);
   end

endmodule

// File: rtl/fir_sym_tdm.sv
// Odd-length linear-phase FIR with one time-shared pre-add/MAC lane and round+saturate.
// Define FIR_COEF_WR_EN to make the unique coefficients writable while idle.
//
// state | meaning
// IDLE  | in_ready high, waiting for a sample
// MAC   | one unique coefficient per cycle, idx 0..NU-1
// ROUND | round, saturate, register out_data
// OUT   | hold out_data until out_ready
module fir_sym_tdm
   import fir_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int COEF_W     = 16,
   parameter int N_TAPS     = 11,
   parameter int OUT_W      = 16,
   parameter int FRAC_SHIFT = 15
)(
   input  logic                                  clk,
   input  logic                                  rst,
   fir_sym_tdm_if.slave                          bus,
   output logic                                  busy,
   input  logic                                  coef_wr_en,
   input  logic [$clog2(calc_nu(N_TAPS))-1:0]    coef_wr_addr,
   input  logic signed [COEF_W-1:0]              coef_wr_data
);

   localparam int NU    = calc_nu(N_TAPS);
   localparam int CA_W  = $clog2(NU);
   localparam int ACC_W = calc_acc_w(DATA_W, COEF_W, N_TAPS);
   localparam logic [CA_W-1:0] IDX_LAST = CA_W'(NU - 1);

   fir_state_t state, state_nxt;

   logic [CA_W-1:0]          idx;
   logic signed [DATA_W-1:0] dly [N_TAPS];
   logic signed [COEF_W-1:0] coef [NU];

   logic                     in_ready_q;
   logic                     out_valid_q;
   logic signed [OUT_W-1:0]  out_data_q;

   logic                     accept;
   logic                     mac_en;
   logic                     last_mac;
   logic                     ld_out;
   logic                     out_done;

   logic signed [DATA_W-1:0] tap_a;
   logic signed [DATA_W-1:0] tap_b;
   logic signed [COEF_W-1:0] tap_c;
   logic                     centre;
   logic signed [ACC_W-1:0]  acc;
   logic signed [63:0]       acc_ext;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept)       state_nxt = S_MAC;
         S_MAC:   if (last_mac)     state_nxt = S_ROUND;
         S_ROUND:                   state_nxt = S_OUT;
         S_OUT:   if (bus.out_ready) state_nxt = S_IDLE;
         default:                   state_nxt = S_IDLE;
      endcase
   end

   // Accept only against the registered in_ready so the first idle cycle after
   // reset cannot swallow a sample the source still thinks is pending.
   always_comb begin
      accept   = bus.in_valid && in_ready_q;
      mac_en   = (state == S_MAC);
      last_mac = mac_en && (idx == IDX_LAST);
      ld_out   = (state == S_ROUND);
      out_done = (state == S_OUT) && bus.out_ready;
      busy     = (state != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx         <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int k = 0; k < N_TAPS; k++) dly[k] <= '0;
      end else begin
         in_ready_q <= (state_nxt == S_IDLE);
         if (accept) begin
            dly[0] <= bus.in_data;
            for (int k = 1; k < N_TAPS; k++) dly[k] <= dly[k-1];
            idx <= '0;
         end else if (mac_en && !last_mac) begin
            idx <= idx + CA_W'(1);
         end
         if (ld_out) begin
            out_data_q  <= OUT_W'(round_sat(acc_ext, FRAC_SHIFT, OUT_W));
            out_valid_q <= 1'b1;
         end else if (out_done) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   // Mirror-pair select: d[idx] with d[N_TAPS-1-idx]; centre tap has no partner.
   always_comb begin
      tap_a  = '0;
      tap_b  = '0;
      tap_c  = '0;
      centre = (idx == IDX_LAST);
      for (int k = 0; k < NU; k++) begin
         if (idx == CA_W'(k)) begin
            tap_a = dly[k];
            tap_b = dly[N_TAPS-1-k];
            tap_c = coef[k];
         end
      end
   end

`ifdef FIR_COEF_WR_EN
   // Writes land on the same edge as an accepted sample, ahead of its first MAC.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NU; k++) coef[k] <= COEF_W'(def_coef(k));
      end else if (coef_wr_en && !busy) begin
         for (int k = 0; k < NU; k++) begin
            if (coef_wr_addr == CA_W'(k)) coef[k] <= coef_wr_data;
         end
      end
   end
`else
   logic unused_coef_wr;
   assign unused_coef_wr = ^{coef_wr_en, coef_wr_addr, coef_wr_data};

   always_comb begin
      for (int k = 0; k < NU; k++) coef[k] = COEF_W'(def_coef(k));
   end
`endif

   fir_preadd_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .en     (mac_en),
      .centre (centre),
      .tap_a  (tap_a),
      .tap_b  (tap_b),
      .coef   (tap_c),
      .acc    (acc)
   );

   assign acc_ext = {{(64-ACC_W){acc[ACC_W-1]}}, acc};

endmodule

// File: tb/tb_fir_sym_tdm.sv
// Scoreboard bench for fir_sym_tdm: direct-form reference model, impulse, timing,
// backpressure, reset abort and (with FIR_COEF_WR_EN) saturation.
module tb_fir_sym_tdm;

   localparam int NU     = 6;
   localparam int N_TAPS = 11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic               busy;
   logic               coef_wr_en;
   logic [2:0]         coef_wr_addr;
   logic signed [15:0] coef_wr_data;

   fir_sym_tdm_if #(.DATA_W(16), .OUT_W(16)) bus ();

   fir_sym_tdm #(
      .DATA_W(16), .COEF_W(16), .N_TAPS(N_TAPS), .OUT_W(16), .FRAC_SHIFT(15)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave),
      .busy         (busy),
      .coef_wr_en   (coef_wr_en),
      .coef_wr_addr (coef_wr_addr),
      .coef_wr_data (coef_wr_data)
   );

   int     n_checks = 0;
   int     n_errors = 0;
   longint exp_q [$];
   longint hist [N_TAPS];
   longint coef_m [NU];
   longint imp_exp [12] = '{82, -491, 656, -983, 2458, 8192, 2458, -983, 656, -491, 82, 0};

   task automatic check_val(input string tag, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < N_TAPS; k++) hist[k] = 0;
      coef_m[0] = 164;   coef_m[1] = -983; coef_m[2] = 1311;
      coef_m[3] = -1966; coef_m[4] = 4915; coef_m[5] = 16384;
   endfunction

   // Full direct-form convolution over all 11 taps, h[k] = h[10-k].
   function automatic longint model_step(input longint x);
      longint acc;
      longint r;
      for (int k = N_TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
      acc = 0;
      for (int k = 0; k < N_TAPS; k++)
         acc += hist[k] * coef_m[(k < NU) ? k : (N_TAPS - 1 - k)];
      r = (acc + 16384) >>> 15;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) check_val("out_unexpected", 0, 1);
         else                   check_val("out_data", bus.out_data, exp_q.pop_front());
      end
   end

   task automatic send(input logic signed [15:0] x, input longint exp);
      bit rdy;
      bit ok;
      ok = 1'b0;
      bus.in_data  = x;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         rdy = bus.in_ready;
         @(posedge clk); #1;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      bus.in_valid = 1'b0;
      check_val("send_accept", ok, 1);
      if (ok) exp_q.push_back(exp);
   endtask

   task automatic wr_coef(input logic [2:0] addr, input logic signed [15:0] data);
      coef_wr_en   = 1'b1;
      coef_wr_addr = addr;
      coef_wr_data = data;
      @(posedge clk); #1;
      coef_wr_en   = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("drain", exp_q.size(), 0);
   endtask

   // Centre-tap write attempted mid-MAC must not disturb the 8192 output.
   task automatic run_impulse();
      logic signed [15:0] x;
      for (int i = 0; i < 12; i++) begin
         x = (i == 0) ? 16'sd16384 : 16'sd0;
         void'(model_step(x));
         send(x, imp_exp[i]);
         if (i == 5) begin
            check_val("busy_in_mac", busy, 1);
            wr_coef(3'd5, 16'sd0);
         end
      end
      drain();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int                 cnt;
      logic signed [15:0] held;
      logic signed [15:0] x;
      longint             e;

      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      coef_wr_en    = 1'b0;
      coef_wr_addr  = '0;
      coef_wr_data  = '0;
      model_reset();

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_in_ready", bus.in_ready, 0);
      check_val("rst_out_valid", bus.out_valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_out_data", bus.out_data, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_val("in_ready_after_rst", bus.in_ready, 1);

      run_impulse();

      // latency: accept edge -> out_valid after NU+1 further edges
      e = model_step(1000);
      send(16'sd1000, e);
      check_val("ready_low_T1", bus.in_ready, 0);
      cnt = 0;
      while (!bus.out_valid && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
         if (!bus.out_valid) check_val("ready_low_mac", bus.in_ready, 0);
      end
      check_val("latency", cnt, NU + 1);
      check_val("ready_low_out", bus.in_ready, 0);
      @(posedge clk); #1;
      check_val("ready_after_hs", bus.in_ready, 1);
      check_val("valid_after_hs", bus.out_valid, 0);
      drain();

      // backpressure with a second sample held off
      bus.out_ready = 1'b0;
      e = model_step(-5000);
      send(-16'sd5000, e);
      cnt = 0;
      while (!bus.out_valid && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      check_val("bp_valid", bus.out_valid, 1);
      held = bus.out_data;
      bus.in_data  = 16'sd1234;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_val("bp_valid_hold", bus.out_valid, 1);
         check_val("bp_data_hold", bus.out_data, held);
         check_val("bp_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      e = model_step(1234);
      send(16'sd1234, e);
      drain();

      for (int i = 0; i < 20; i++) begin
         x = 16'($urandom);
         e = model_step(x);
         send(x, e);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      drain();

      // abort on MAC cycle 3
      e = model_step(7777);
      send(16'sd7777, e);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_val("abort_out_valid", bus.out_valid, 0);
      check_val("abort_busy", busy, 0);
      void'(exp_q.pop_back());
      model_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      run_impulse();

`ifdef FIR_COEF_WR_EN
      wr_coef(3'd4, 16'sd32767);
      wr_coef(3'd5, 16'sd32767);
      wr_coef(3'd7, 16'sd0);
      coef_m[4] = 32767;
      coef_m[5] = 32767;
      for (int i = 0; i < 11; i++) begin
         e = model_step(32767);
         send(16'sd32767, (i == 10) ? 64'sd32767 : e);
      end
      drain();
      for (int i = 0; i < 11; i++) begin
         e = model_step(-32768);
         send(-16'sd32768, (i == 10) ? -64'sd32768 : e);
      end
      drain();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
